// File: rtl/io_map_pkg.sv
// Shared I/O register map for the memory-stage data memory and I/O block.
// Offsets are word offsets (addr[4:2]) from the I/O base.
package io_map_pkg;

  localparam logic [2:0] IO_IN0     = 3'd0;
  localparam logic [2:0] IO_IN1     = 3'd1;
  localparam logic [2:0] IO_OUT0    = 3'd2;
  localparam logic [2:0] IO_OUT1    = 3'd3;
  localparam logic [2:0] IO_OUT2    = 3'd4;
  localparam logic [2:0] IO_CYCLES  = 3'd5;
  localparam logic [2:0] IO_STATUS  = 3'd6;

  localparam int STATUS_IN0_BIT = 0;
  localparam int STATUS_IN1_BIT = 1;
  localparam int STATUS_BITS    = 2;

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for an external input bus plus a history flop
// that yields a one-cycle change indication on the synchronized value.
module input_sync #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] raw,
  output logic [W-1:0] value,
  output logic         changed
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign value   = s2;
  assign changed = (s2 != s3);

endmodule

// File: rtl/data_io_mem.sv
// MEM-stage data memory with memory-mapped I/O: word RAM, output ports,
// synchronized inputs with sticky change flags and a loadable cycle counter.
module data_io_mem
  import io_map_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 5,
  parameter int IN_W          = 10
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  output logic [31:0]     rdata,
  input  logic [IN_W-1:0] in_port0,
  input  logic [IN_W-1:0] in_port1,
  output logic [31:0]     out_port0,
  output logic [31:0]     out_port1,
  output logic [31:0]     out_port2
);

  localparam int SEL_BIT   = RAM_ADDR_BITS + 2;
  localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;
  localparam int PAD_W     = 32 - IN_W;

  // Address decode; bits above SEL_BIT and the byte offset are don't-care.
  logic                     io_sel;
  logic [RAM_ADDR_BITS-1:0] word;
  logic [2:0]               io_off;
  logic                     wr_ram;
  logic                     wr_io;
  logic                     unused_addr;

  assign io_sel      = addr[SEL_BIT];
  assign word        = addr[RAM_ADDR_BITS+1:2];
  assign io_off      = addr[4:2];
  assign wr_ram      = we && !io_sel;
  assign wr_io       = we && io_sel;
  assign unused_addr = ^{addr[1:0], addr[31:SEL_BIT+1]};

  // RAM: asynchronous read, no reset; a store coinciding with reset is dropped.
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (wr_ram && resetn) begin
      ram[word] <= wdata;
    end
  end

  // Input synchronizers
  logic [IN_W-1:0] in0_q;
  logic [IN_W-1:0] in1_q;
  logic            in0_chg;
  logic            in1_chg;

  input_sync #(.W(IN_W)) u_sync0 (
    .clock   (clock),
    .resetn  (resetn),
    .raw     (in_port0),
    .value   (in0_q),
    .changed (in0_chg)
  );

  input_sync #(.W(IN_W)) u_sync1 (
    .clock   (clock),
    .resetn  (resetn),
    .raw     (in_port1),
    .value   (in1_q),
    .changed (in1_chg)
  );

  // Register file write enables
  logic wr_out0;
  logic wr_out1;
  logic wr_out2;
  logic wr_cycles;
  logic wr_status;

  assign wr_out0   = wr_io && (io_off == IO_OUT0);
  assign wr_out1   = wr_io && (io_off == IO_OUT1);
  assign wr_out2   = wr_io && (io_off == IO_OUT2);
  assign wr_cycles = wr_io && (io_off == IO_CYCLES);
  assign wr_status = wr_io && (io_off == IO_STATUS);

  logic [31:0]            cycles;
  logic [STATUS_BITS-1:0] flags;
  logic [STATUS_BITS-1:0] flag_set;
  logic [STATUS_BITS-1:0] flag_clr;
  logic [STATUS_BITS-1:0] flags_next;

  // Set has priority over a same-edge write-1-to-clear.
  always_comb begin
    flag_set                 = '0;
    flag_set[STATUS_IN0_BIT] = in0_chg;
    flag_set[STATUS_IN1_BIT] = in1_chg;
    flag_clr                 = wr_status ? wdata[STATUS_BITS-1:0] : '0;
    flags_next               = (flags & ~flag_clr) | flag_set;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
      cycles    <= '0;
      flags     <= '0;
    end else begin
      if (wr_out0) out_port0 <= wdata;
      if (wr_out1) out_port1 <= wdata;
      if (wr_out2) out_port2 <= wdata;
      cycles <= wr_cycles ? wdata : cycles + 32'd1;
      flags  <= flags_next;
    end
  end

  // Load path is purely combinational so forwarding sees it in MEM.
  always_comb begin
    rdata = '0;
    if (!io_sel) begin
      rdata = ram[word];
    end else begin
      case (io_off)
        IO_IN0:    rdata = {{PAD_W{1'b0}}, in0_q};
        IO_IN1:    rdata = {{PAD_W{1'b0}}, in1_q};
        IO_OUT0:   rdata = out_port0;
        IO_OUT1:   rdata = out_port1;
        IO_OUT2:   rdata = out_port2;
        IO_CYCLES: rdata = cycles;
        IO_STATUS: rdata = {{(32-STATUS_BITS){1'b0}}, flags};
        default:   rdata = '0;
      endcase
    end
  end

endmodule
